// File: rtl/uart_tx_arbiter_if.sv
// Requester, UART-control and completion-report signals of uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  logic [16:0] cfg_baud;
  logic [3:0]  cfg_length;
  logic        cfg_parity_en;
  logic        cfg_parity_type;
  logic        cfg_stop2;

  logic        tx_start;
  logic [7:0]  tx_data;
  logic [16:0] baud;
  logic [3:0]  length;
  logic        parity_en;
  logic        parity_type;
  logic        stop2;
  logic        tx_done;
  logic        tx_err;

  logic           done_valid;
  logic [IDW-1:0] done_id;
  logic           done_err;
  logic           timeout;
  logic           busy;

  modport slave (
    input  req_valid, req_data, cfg_baud, cfg_length, cfg_parity_en,
           cfg_parity_type, cfg_stop2, tx_done, tx_err,
    output req_ready, tx_start, tx_data, baud, length, parity_en, parity_type,
           stop2, done_valid, done_id, done_err, timeout, busy
  );

  modport master (
    output req_valid, req_data, cfg_baud, cfg_length, cfg_parity_en,
           cfg_parity_type, cfg_stop2, tx_done, tx_err,
    input  req_ready, tx_start, tx_data, baud, length, parity_en, parity_type,
           stop2, done_valid, done_id, done_err, timeout, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX among NREQ byte requesters; accept->tx_start 1 cycle, tx_done->report 1 cycle.
// Requesters are held off (req_ready=0) while a frame is in START/WAIT; a watchdog aborts frames with no tx_done.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int TMO_CYCLES = 1000000,
  parameter int IDW        = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int             WDW    = $clog2(TMO_CYCLES);
  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [16:0]    baud_q, baud_d;
  logic [3:0]     length_q, length_d;
  logic           pe_q, pe_d, pt_q, pt_d, s2_q, s2_d;
  logic           done_valid_q, done_valid_d;
  logic [IDW-1:0] done_id_q, done_id_d;
  logic           done_err_q, done_err_d;
  logic           timeout_q, timeout_d;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;
  logic           accept;
  logic           wd_hit;

  // Walk from lowest to highest priority so the nearest requester after last_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    cand    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      sum  = {1'b0, last_q} + (IDW+1)'(i);
      cand = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : IDW'(sum);
      if (bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign accept = (state_q == S_IDLE) && gnt_vld;
  assign wd_hit = (wdog_q == WD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (bus.tx_done || wd_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    baud_d       = baud_q;
    length_d     = length_q;
    pe_d         = pe_q;
    pt_d         = pt_q;
    s2_d         = s2_q;
    last_d       = last_q;
    wdog_d       = wdog_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;
    done_err_d   = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tx_start_d = 1'b1;
          tx_data_d  = bus.req_data[{gnt_id, 3'b000} +: 8];
          baud_d     = bus.cfg_baud;
          length_d   = bus.cfg_length;
          pe_d       = bus.cfg_parity_en;
          pt_d       = bus.cfg_parity_type;
          s2_d       = bus.cfg_stop2;
          last_d     = gnt_id;
        end
      end
      S_START: wdog_d = '0;
      S_WAIT: begin
        wdog_d = wdog_q + WDW'(1);
        // tx_done on the threshold cycle still counts as a real completion.
        if (bus.tx_done) begin
          done_valid_d = 1'b1;
          done_id_d    = last_q;
          done_err_d   = bus.tx_err;
        end else if (wd_hit) begin
          done_valid_d = 1'b1;
          done_id_d    = last_q;
          done_err_d   = 1'b1;
          timeout_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= IDW'(NREQ - 1);
      wdog_q       <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      baud_q       <= '0;
      length_q     <= '0;
      pe_q         <= 1'b0;
      pt_q         <= 1'b0;
      s2_q         <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      last_q       <= last_d;
      wdog_q       <= wdog_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      baud_q       <= baud_d;
      length_q     <= length_d;
      pe_q         <= pe_d;
      pt_q         <= pt_d;
      s2_q         <= s2_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_err_q   <= done_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.req_ready   = accept ? (NREQ'(1) << gnt_id) : '0;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.baud        = baud_q;
  assign bus.length      = length_q;
  assign bus.parity_en   = pe_q;
  assign bus.parity_type = pt_q;
  assign bus.stop2       = s2_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_id     = done_id_q;
  assign bus.done_err    = done_err_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected frames and reports are queued by the stimulus
// and consumed by a negedge monitor; a UART model answers tx_start with tx_done.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus();
  uart_tx_arbiter #(.NREQ(NREQ), .TMO_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {logic [7:0] data; logic [16:0] baud; logic [3:0] len; logic [2:0] flags;} start_t;
  typedef struct packed {logic [1:0] id; logic err; logic tmo; logic acc;} done_t;
  typedef struct packed {logic [3:0] tag; logic [63:0] exp;} probe_t;

  localparam logic [3:0] T_READY = 4'd0, T_BAUD = 4'd1, T_BUSY = 4'd2, T_ZERO = 4'd3,
                         T_BOUND = 4'd4, T_LEFT_S = 4'd5, T_LEFT_D = 4'd6;

  start_t exp_start[$];
  done_t  exp_done[$];
  probe_t probes[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_starts = 0;
  logic resp_en  = 1'b1;
  logic resp_err = 1'b0;
  int   resp_delay = 10;
  logic resp_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] info);
    n_checks++;
    n_fail++;
    $display("FAIL %s: observed 0x%0h where nothing was expected", name, info);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a start or a report.
  always @(negedge clk) begin : mon
    probe_t p;
    start_t s;
    done_t  d;
    while (probes.size() > 0) begin
      p = probes.pop_front();
      case (p.tag)
        T_READY:  check("req_ready", 64'(bus.req_ready), p.exp);
        T_BAUD:   check("baud_hold", 64'(bus.baud), p.exp);
        T_BUSY:   check("busy", 64'(bus.busy), p.exp);
        T_ZERO:   check("reset_outputs", 64'({bus.busy, bus.tx_start, bus.tx_data, bus.baud,
                         bus.length, bus.parity_en, bus.parity_type, bus.stop2, bus.done_valid,
                         bus.done_id, bus.done_err, bus.timeout}), p.exp);
        T_BOUND:  flag("wait_bound_expired", p.exp);
        T_LEFT_S: check("leftover_starts", 64'(exp_start.size()), p.exp);
        T_LEFT_D: check("leftover_dones", 64'(exp_done.size()), p.exp);
        default:  flag("bad_probe", 64'(p.tag));
      endcase
    end
    if (!rst) begin
      if (bus.tx_start) begin
        n_starts++;
        if (exp_start.size() == 0) flag("unexpected_tx_start", 64'(bus.tx_data));
        else begin
          s = exp_start.pop_front();
          check("tx_data", 64'(bus.tx_data), 64'(s.data));
          check("baud", 64'(bus.baud), 64'(s.baud));
          check("length", 64'(bus.length), 64'(s.len));
          check("pe_pt_stop2", 64'({bus.parity_en, bus.parity_type, bus.stop2}), 64'(s.flags));
        end
      end
      if (bus.done_valid) begin
        if (exp_done.size() == 0) flag("unexpected_done", 64'(bus.done_id));
        else begin
          d = exp_done.pop_front();
          check("done_id", 64'(bus.done_id), 64'(d.id));
          check("done_err", 64'(bus.done_err), 64'(d.err));
          check("timeout", 64'(bus.timeout), 64'(d.tmo));
          check("accept_with_done", 64'(bus.req_ready != '0), 64'(d.acc));
        end
      end else if (bus.timeout) flag("timeout_without_done", 64'(bus.timeout));
    end
  end

  // UART model: answers each tx_start with a one-cycle tx_done resp_delay cycles later.
  initial begin : uart
    int   dly;
    logic er;
    bus.tx_done = 1'b0;
    bus.tx_err  = 1'b0;
    resp_busy   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_start && resp_en) begin
        resp_busy = 1'b1;
        dly = resp_delay;
        er  = resp_err;
        repeat (dly) @(posedge clk);
        #1 bus.tx_done = 1'b1; bus.tx_err = er;
        @(posedge clk);
        #1 bus.tx_done = 1'b0; bus.tx_err = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  function automatic start_t mk_s(input logic [7:0] dt, input logic [16:0] b,
                                  input logic [3:0] l, input logic [2:0] f);
    return '{data: dt, baud: b, len: l, flags: f};
  endfunction

  function automatic done_t mk_d(input logic [1:0] id, input logic e, input logic t, input logic a);
    return '{id: id, err: e, tmo: t, acc: a};
  endfunction

  task automatic probe(input logic [3:0] tag, input logic [63:0] e);
    probe_t p;
    p.tag = tag;
    p.exp = e;
    probes.push_back(p);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise setm, wait for the grant, check it is exp_rdy, then drop the granted request.
  task automatic send(input logic [3:0] setm, input logic [3:0] exp_rdy);
    int k;
    bus.req_valid = bus.req_valid | setm;
    #1;
    k = 0;
    while (bus.req_ready == '0 && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 200) probe(T_BOUND, 64'(k));
    else          probe(T_READY, 64'(exp_rdy));
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~exp_rdy;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (k < budget && !(exp_start.size() == 0 && exp_done.size() == 0 && !bus.busy && !resp_busy)) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= budget) probe(T_BOUND, 64'(k));
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int k;
    bus.req_valid = '0;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.cfg_baud = 17'd100;
    bus.cfg_length = 4'd8;
    bus.cfg_parity_en = 1'b0;
    bus.cfg_parity_type = 1'b0;
    bus.cfg_stop2 = 1'b0;
    tick(3);
    probe(T_ZERO, 64'd0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Round robin from reset: 0,1,2,3,0,1, each new accept coinciding with done_valid.
    resp_delay = 10;
    for (int i = 0; i < 6; i++) begin
      exp_start.push_back(mk_s(8'h10 + 8'(i % 4), 17'd100, 4'd8, 3'b000));
      exp_done.push_back(mk_d(2'(i % 4), 1'b0, 1'b0, i < 5));
    end
    bus.req_valid = 4'b1111;
    probe(T_READY, 64'(4'b0001));
    k = 0;
    while (n_starts < 6 && k < 400) begin
      tick(1);
      k++;
    end
    if (k >= 400) probe(T_BOUND, 64'(k));
    bus.req_valid = '0;
    wait_idle(200);

    // Single byte from requester 0.
    bus.req_data = {8'h4D, 8'h3C, 8'h2B, 8'hA5};
    bus.cfg_baud = 17'd5208;
    resp_delay = 12;
    exp_start.push_back(mk_s(8'hA5, 17'd5208, 4'd8, 3'b000));
    exp_done.push_back(mk_d(2'd0, 1'b0, 1'b0, 1'b0));
    send(4'b0001, 4'b0001);
    wait_idle(100);

    // UART error from requester 2, with parity/stop2 config latched.
    bus.cfg_length = 4'd7;
    bus.cfg_parity_en = 1'b1;
    bus.cfg_parity_type = 1'b1;
    bus.cfg_stop2 = 1'b1;
    resp_err = 1'b1;
    exp_start.push_back(mk_s(8'h3C, 17'd5208, 4'd7, 3'b111));
    exp_done.push_back(mk_d(2'd2, 1'b1, 1'b0, 1'b0));
    send(4'b0100, 4'b0100);
    wait_idle(100);
    resp_err = 1'b0;
    bus.cfg_length = 4'd8;
    bus.cfg_parity_en = 1'b0;
    bus.cfg_parity_type = 1'b0;
    bus.cfg_stop2 = 1'b0;

    // Watchdog fires; the late tx_done three cycles after the report is ignored.
    resp_delay = 20;
    exp_start.push_back(mk_s(8'h2B, 17'd5208, 4'd8, 3'b000));
    exp_done.push_back(mk_d(2'd1, 1'b1, 1'b1, 1'b0));
    send(4'b0010, 4'b0010);
    wait_idle(100);

    // tx_done on the threshold cycle wins over the watchdog.
    resp_delay = 16;
    exp_start.push_back(mk_s(8'h4D, 17'd5208, 4'd8, 3'b000));
    exp_done.push_back(mk_d(2'd3, 1'b0, 1'b0, 1'b0));
    send(4'b1000, 4'b1000);
    wait_idle(100);

    // cfg_baud change during WAIT only takes effect at the next accept.
    resp_delay = 12;
    exp_start.push_back(mk_s(8'hA5, 17'd5208, 4'd8, 3'b000));
    exp_done.push_back(mk_d(2'd0, 1'b0, 1'b0, 1'b0));
    send(4'b0001, 4'b0001);
    tick(4);
    bus.cfg_baud = 17'd434;
    probe(T_BAUD, 64'd5208);
    probe(T_BUSY, 64'd1);
    wait_idle(100);
    probe(T_BAUD, 64'd5208);
    exp_start.push_back(mk_s(8'h2B, 17'd434, 4'd8, 3'b000));
    exp_done.push_back(mk_d(2'd1, 1'b0, 1'b0, 1'b0));
    send(4'b0010, 4'b0010);
    wait_idle(100);

    // Reset during WAIT aborts silently; afterwards requester 0 has top priority.
    resp_en = 1'b0;
    exp_start.push_back(mk_s(8'h4D, 17'd434, 4'd8, 3'b000));
    send(4'b1000, 4'b1000);
    tick(4);
    rst = 1'b1;
    #1;
    probe(T_ZERO, 64'd0);
    tick(2);
    resp_en = 1'b1;
    rst = 1'b0;
    tick(1);
    exp_start.push_back(mk_s(8'hA5, 17'd434, 4'd8, 3'b000));
    exp_done.push_back(mk_d(2'd0, 1'b0, 1'b0, 1'b1));
    exp_start.push_back(mk_s(8'h4D, 17'd434, 4'd8, 3'b000));
    exp_done.push_back(mk_d(2'd3, 1'b0, 1'b0, 1'b0));
    send(4'b1001, 4'b0001);
    send(4'b0000, 4'b1000);
    wait_idle(100);

    probe(T_LEFT_S, 64'd0);
    probe(T_LEFT_D, 64'd0);
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NREQ byte-stream requesters.
- Accepts one byte at a time from requesters over valid/ready.
- Latches the global frame configuration at accept time and drives the UART TX control signals: tx_start, tx_data, baud, length, parity, stop2.
- Waits for tx_done, with a timeout watchdog, then reports per-frame completion status tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters (2..16)
- TMO_CYCLES, 1000000, maximum WAIT-state cycles before a frame is declared timed out (>=2)
- IDW, $clog2(NREQ), requester ID width (derived; do not override)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  NREQ*8  requester i byte at [8i+7:8i]
- req_ready  out  NREQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
- cfg_baud  in  17  global baud divisor, sampled at accept
- cfg_length  in  4  data bits per frame, sampled at accept
- cfg_parity_en  in  1  parity enable, sampled at accept
- cfg_parity_type  in  1  parity type, sampled at accept
- cfg_stop2  in  1  two stop bits, sampled at accept
- tx_start  out  1  one-cycle start pulse to the UART TX
- tx_data  out  8  byte for the UART TX
- baud  out  17  latched config to the UART
- length  out  4  latched config to the UART
- parity_en  out  1  latched config to the UART
- parity_type  out  1  latched config to the UART
- stop2  out  1  latched config to the UART
- tx_done  in  1  UART frame-complete pulse
- tx_err  in  1  UART error, qualified by tx_done
- done_valid  out  1  one-cycle completion report
- done_id  out  IDW  requester that owned the completed frame
- done_err  out  1  tx_err or timeout for that frame
- timeout  out  1  one-cycle pulse, frame aborted by watchdog
- busy  out  1  high in START or WAIT

Behaviour:
- Reset (async, immediate):
  - State IDLE; all registered outputs 0 (tx_start, tx_data, baud, length, parity_en, parity_type, stop2, done_valid, done_id, done_err, timeout).
  - RR pointer set so requester 0 has top priority (last_grant = NREQ-1); watchdog cleared.
- States: IDLE, START, WAIT.
- IDLE:
  - Grant = first set req_valid bit searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready = one-hot grant, combinational, only in IDLE; all zero in other states.
  - On the accept edge: latch req_data of the grantee into tx_data; latch all cfg_* into the config outputs; record the ID; last_grant <= ID; tx_start <= 1; go to START.
  - No valid: stay in IDLE; outputs hold.
- START (1 cycle): tx_start = 1. Next edge: tx_start <= 0, watchdog <= 0, go to WAIT. tx_done here is ignored.
- WAIT: watchdog increments each cycle.
  - tx_done = 1: done_valid <= 1, done_id <= ID, done_err <= tx_err, timeout <= 0, go to IDLE.
  - Else if watchdog == TMO_CYCLES-1: done_valid <= 1, done_err <= 1, timeout <= 1, go to IDLE.
  - tx_done in the same cycle as the timeout threshold: tx_done wins, no timeout.
- done_valid, done_err and timeout are one-cycle pulses. done_id holds its value until the next report.
- Latency: accept at cycle T; tx_start high in T+1; WAIT from T+2; tx_done at cycle D gives done_valid in D+1. A new grant is possible in D+1, so done and accept may coincide.
- Config and tx_data outputs stay stable from accept until the next accept; cfg_* changes in START/WAIT have no effect.
- tx_done or tx_err in IDLE or START: ignored, no report. tx_err without tx_done: ignored.
- Late tx_done after a timeout (state IDLE): ignored.
- A requester that drops req_valid before ready is simply not granted.
- Reset mid-frame: frame aborted silently, no done_valid.

Test Plan:
- Single byte: req_valid=4'b0001, req_data[7:0]=8'hA5, cfg_baud=17'd5208, cfg_length=8 -> req_ready=4'b0001 same cycle; next cycle tx_start=1, tx_data=8'hA5, baud=5208, length=8; tx_done 100 cycles later -> done_valid=1, done_id=0, done_err=0 in the following cycle.
- Round robin: all four valid continuously, tx_done returned 10 cycles after each tx_start -> grant order 0,1,2,3,0,1; each new accept in the cycle done_valid is high.
- Error: tx_done=1 with tx_err=1 for requester 2 -> done_valid=1, done_id=2, done_err=1, timeout=0.
- Watchdog (TMO_CYCLES=16): no tx_done -> done_valid=1, done_err=1, timeout=1 on the 17th cycle after entering WAIT; a tx_done 3 cycles later produces no report; tx_done exactly on the threshold cycle -> done_err=tx_err, timeout=0.
- Config stability: change cfg_baud from 5208 to 434 during WAIT -> baud output stays 5208 until the next accept, then 434.
- Reset mid-frame: assert rst in WAIT -> all outputs 0 immediately, no done_valid; after release with req_valid=4'b1001 -> requester 0 granted first.
